// File: rtl/sb_pkg.sv
// sb_pkg: width codes, store entry record and control state shared by the store buffer
package sb_pkg;
  localparam logic [2:0] WIDTH_B = 3'b000;
  localparam logic [2:0] WIDTH_H = 3'b001;
  localparam logic [2:0] WIDTH_W = 3'b010;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
  } sb_entry_t;
  typedef enum logic {RUN, FLUSH} sb_state_t;
endpackage

// File: rtl/sb_match.sv
// sb_match: word-address match of a load against buffered stores, picking the youngest hit
// Ports: i_valid/i_word per entry, i_head (oldest slot), i_ld_valid/i_ld_word load probe;
//        o_match any hit, o_idx slot of the youngest hit.
module sb_match import sb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [29:0]              i_word [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic                     i_ld_valid,
  input  logic [29:0]              i_ld_word,
  output logic                     o_match,
  output logic [$clog2(DEPTH)-1:0] o_idx
);
  localparam int PW = $clog2(DEPTH);
  // Walk oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    o_match = 1'b0;
    o_idx   = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_ld_valid && i_valid[i_head + PW'(k)] && i_word[i_head + PW'(k)] == i_ld_word) begin
        o_match = 1'b1;
        o_idx   = i_head + PW'(k);
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to data memory, with load hazard detection and flush
// Ports: clk/reset; st_* store push (st_ready back-pressure); ld_* load probe with ld_stall and
//        ld_fwd_* forwarding result; mem_* write port yielding to mem_busy; flush_req/flush_done;
//        count occupancy. Macro SB_FORWARD_EN enables aligned word store-to-load forwarding.
module store_buffer import sb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             st_width,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_width,
  output logic                   ld_stall,
  output logic                   ld_fwd_valid,
  output logic [31:0]            ld_fwd_data,
  output logic                   mem_write_enable,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_write_data,
  output logic [2:0]             mem_width,
  input  logic                   mem_busy,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  sb_entry_t        r_ent [DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count, w_count_next;
  sb_state_t        r_state, w_state_next;
  logic             r_flush_done, w_flush_done_next;
  logic             w_push, w_pop, w_match, w_unused;
  logic [PW-1:0]    w_idx;
  logic [DEPTH-1:0] w_valid;
  logic [29:0]      w_word [DEPTH];
  assign st_ready         = r_count < CW'(DEPTH) && r_state == RUN;
  assign w_push           = st_valid && st_ready;
  // Nothing may reach memory in the cycle reset is asserted.
  assign mem_write_enable = !reset && r_count != '0 && !mem_busy;
  assign w_pop            = mem_write_enable;
  assign mem_addr         = mem_write_enable ? r_ent[r_head].addr  : '0;
  assign mem_write_data   = mem_write_enable ? r_ent[r_head].data  : '0;
  assign mem_width        = mem_write_enable ? r_ent[r_head].width : '0;
  assign w_count_next     = r_count + CW'(w_push) - CW'(w_pop);
  assign count            = r_count;
  assign flush_done       = r_flush_done;
  always_comb begin
    w_state_next      = r_state == RUN ? (flush_req ? FLUSH : RUN) : (w_count_next == '0 ? RUN : FLUSH);
    w_flush_done_next = r_state == FLUSH && w_count_next == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_done <= w_flush_done_next;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_ent[k].valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_push) begin
        r_ent[r_tail] <= '{valid: 1'b1, addr: st_addr, data: st_data, width: st_width};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= w_count_next;
    end
  end
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_valid[k] = r_ent[k].valid;
      w_word[k]  = r_ent[k].addr[31:2];
    end
  end
  sb_match #(.DEPTH(DEPTH)) u_match (
    .i_valid   (w_valid),
    .i_word    (w_word),
    .i_head    (r_head),
    .i_ld_valid(ld_valid),
    .i_ld_word (ld_addr[31:2]),
    .o_match   (w_match),
    .o_idx     (w_idx)
  );
`ifdef SB_FORWARD_EN
  logic w_fwd;
  assign w_fwd        = w_match && r_ent[w_idx].width == WIDTH_W && r_ent[w_idx].addr[1:0] == 2'b00 && ld_width == WIDTH_W;
  assign ld_fwd_valid = w_fwd;
  assign ld_fwd_data  = w_fwd ? r_ent[w_idx].data : '0;
  assign ld_stall     = w_match && !w_fwd;
  assign w_unused     = &{1'b0, ld_addr[1:0]};
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
  assign ld_stall     = w_match;
  assign w_unused     = &{1'b0, ld_addr[1:0], ld_width, w_idx};
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a scoreboard of expected memory writes checked by a monitor
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset, st_valid, st_ready, ld_valid, ld_stall, ld_fwd_valid;
  logic [31:0] st_addr, st_data, ld_addr, ld_fwd_data, mem_addr, mem_write_data;
  logic [2:0]  st_width, ld_width, mem_width;
  logic        mem_write_enable, mem_busy, flush_req, flush_done;
  logic [$clog2(DEPTH):0] count;
  int total = 0;
  int bad = 0;
  logic [66:0] exp_q [$];
  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_width(st_width),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_width(ld_width),
    .ld_stall(ld_stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_width(mem_width), .mem_busy(mem_busy), .flush_req(flush_req), .flush_done(flush_done),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_write_data, mem_width}, 96'h0);
      else chk("write_order", {mem_addr, mem_write_data, mem_width}, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w, input bit expect_write);
    chk("push_ready", st_ready, 1);
    st_valid = 1; st_addr = a; st_data = d; st_width = w;
    if (expect_write) exp_q.push_back({a, d, w});
    tick();
    st_valid = 0;
  endtask
  task automatic load_chk(input string nm, input logic [31:0] a, input logic stall, input logic fv, input logic [31:0] fd);
    ld_valid = 1; ld_addr = a; ld_width = 3'b010;
    #1;
    chk({nm, "_stall"}, ld_stall, stall);
    chk({nm, "_fwd_valid"}, ld_fwd_valid, fv);
    chk({nm, "_fwd_data"}, ld_fwd_data, fd);
  endtask
  initial begin
    int pulses, when;
    reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_width = 0;
    ld_valid = 0; ld_addr = 0; ld_width = 0; mem_busy = 0; flush_req = 0;
    tick(); tick();
    reset = 0;
    chk("rst_count", count, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_wen", mem_write_enable, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_stall", ld_stall, 0);
    // fill while memory is busy, then full-buffer push with simultaneous drain
    mem_busy = 1;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010, 1);
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    chk("busy_wen", mem_write_enable, 0);
    mem_busy = 0; st_valid = 1; st_addr = 32'h200; st_data = 32'h55; st_width = 3'b010;
    #1;
    chk("full_pop_ready", st_ready, 0);
    chk("head_addr", mem_addr, 32'h100);
    tick();
    st_valid = 0;
    chk("full_no_push", count, 3);
    tick(); tick(); tick();
    chk("drained_count", count, 0);
    chk("idle_wen", mem_write_enable, 0);
    chk("idle_addr_zero", {mem_addr, mem_write_data, mem_width}, 0);
    // aligned word store then word load
    mem_busy = 1;
    push(32'h64, 32'hDEADBEEF, 3'b010, 1);
`ifdef SB_FORWARD_EN
    load_chk("sw_lw", 32'h64, 0, 1, 32'hDEADBEEF);
    mem_busy = 0;
    load_chk("sw_lw_drain", 32'h64, 0, 1, 32'hDEADBEEF);
`else
    load_chk("sw_lw", 32'h64, 1, 0, 0);
    mem_busy = 0;
    load_chk("sw_lw_drain", 32'h64, 1, 0, 0);
`endif
    tick();
    load_chk("sw_lw_after", 32'h64, 0, 0, 0);
    ld_valid = 0;
    // byte store then word load to same word
    mem_busy = 1;
    push(32'h65, 32'hAB, 3'b000, 1);
    load_chk("sb_lw", 32'h64, 1, 0, 0);
    load_chk("sb_other", 32'h68, 0, 0, 0);
    ld_valid = 0;
    #1;
    chk("no_ld_stall", ld_stall, 0);
    tick();
    load_chk("sb_lw_held", 32'h64, 1, 0, 0);
    mem_busy = 0;
    tick();
    load_chk("sb_lw_after", 32'h64, 0, 0, 0);
    ld_valid = 0;
    // youngest matching entry decides
    mem_busy = 1;
    push(32'h64, 32'h11, 3'b000, 1);
    push(32'h64, 32'hCAFEF00D, 3'b010, 1);
    push(32'h70, 32'h12345678, 3'b010, 1);
    push(32'h71, 32'h9A, 3'b000, 1);
`ifdef SB_FORWARD_EN
    load_chk("young_word", 32'h64, 0, 1, 32'hCAFEF00D);
`else
    load_chk("young_word", 32'h64, 1, 0, 0);
`endif
    load_chk("young_byte", 32'h70, 1, 0, 0);
    ld_valid = 0;
    mem_busy = 0;
    tick(); tick(); tick(); tick();
    chk("young_drained", count, 0);
    // streaming push/pop wraps the pointers
    for (int i = 0; i < DEPTH + 2; i++) begin
      st_valid = 1; st_addr = 32'h300 + 32'(4 * i); st_data = 32'hB0 + 32'(i); st_width = 3'b010;
      exp_q.push_back({st_addr, st_data, st_width});
      #1;
      chk("stream_ready", st_ready, 1);
      tick();
    end
    st_valid = 0;
    chk("stream_count", count, 1);
    tick();
    chk("stream_drained", count, 0);
    // flush with three entries
    mem_busy = 1;
    for (int i = 0; i < 3; i++) push(32'h400 + 32'(4 * i), 32'hF0 + 32'(i), 3'b001, 1);
    flush_req = 1;
    tick();
    flush_req = 0;
    chk("flush_ready", st_ready, 0);
    chk("flush_done_early", flush_done, 0);
    mem_busy = 0;
    pulses = 0; when = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (flush_done) begin pulses++; when = i; end
    end
    chk("flush_pulses", pulses, 1);
    chk("flush_when", when, 3);
    chk("flush_back_ready", st_ready, 1);
    // flush with empty buffer
    flush_req = 1;
    tick();
    flush_req = 0;
    chk("eflush_ready", st_ready, 0);
    chk("eflush_done0", flush_done, 0);
    tick();
    chk("eflush_done1", flush_done, 1);
    chk("eflush_run", st_ready, 1);
    tick();
    chk("eflush_done2", flush_done, 0);
    // reset discards buffered stores
    mem_busy = 1;
    push(32'h500, 32'h1, 3'b010, 0);
    push(32'h504, 32'h2, 3'b010, 0);
    chk("pre_rst_count", count, 2);
    reset = 1; mem_busy = 0;
    #1;
    chk("rst_cycle_wen", mem_write_enable, 0);
    tick();
    reset = 0;
    chk("post_rst_count", count, 0);
    tick(); tick();
    chk("post_rst_wen", mem_write_enable, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
